// File: rtl/bus_sequencer_pkg.sv
// Shared constants and types for the fetch/execute bus sequencer.
package bus_sequencer_pkg;

   localparam int unsigned STATE_W   = 3;
   localparam int unsigned BUS_SEL_W = 5;
   localparam int unsigned OPC_W     = 5;
   localparam int unsigned REG_IDX_W = 4;
   localparam int unsigned REG_N     = 16;
   localparam int unsigned IR_W      = 32;

   // FSM state encoding
   localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
   localparam logic [STATE_W-1:0] ST_T0   = 3'd1;
   localparam logic [STATE_W-1:0] ST_T1   = 3'd2;
   localparam logic [STATE_W-1:0] ST_T2   = 3'd3;
   localparam logic [STATE_W-1:0] ST_T3   = 3'd4;
   localparam logic [STATE_W-1:0] ST_T4   = 3'd5;
   localparam logic [STATE_W-1:0] ST_T5   = 3'd6;

   // Shared-bus source codes; R0..R15 map downward from 23
   typedef enum logic [BUS_SEL_W-1:0] {
      BUS_C      = 5'd0,
      BUS_INPORT = 5'd1,
      BUS_MDR    = 5'd2,
      BUS_PC     = 5'd3,
      BUS_ZLOW   = 5'd4,
      BUS_ZHIGH  = 5'd5,
      BUS_LO     = 5'd6,
      BUS_HI     = 5'd7,
      BUS_R0     = 5'd23
   } bus_src_e;

   // Opcodes: 0..OP_ALU_LAST are ALU operations
   localparam logic [OPC_W-1:0] OP_ALU_LAST = 5'd12;
   localparam logic [OPC_W-1:0] OP_MFHI     = 5'd16;
   localparam logic [OPC_W-1:0] OP_MFLO     = 5'd17;

   // Instruction fields occupying ir[31:15]
   typedef struct packed {
      logic [OPC_W-1:0]     opcode;
      logic [REG_IDX_W-1:0] ra;
      logic [REG_IDX_W-1:0] rb;
      logic [REG_IDX_W-1:0] rc;
   } ir_fields_t;

   // Bus code of general register r
   function automatic logic [BUS_SEL_W-1:0] reg_bus_code(input logic [REG_IDX_W-1:0] r);
      return BUS_SEL_W'(BUS_R0) - BUS_SEL_W'(r);
   endfunction

   // One-hot write enable for general register r
   function automatic logic [REG_N-1:0] reg_onehot(input logic [REG_IDX_W-1:0] r);
      logic [REG_N-1:0] v;
      v    = '0;
      v[r] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// Handshake, instruction and control-strobe bundle of the bus sequencer.
interface bus_sequencer_if;
   import bus_sequencer_pkg::*;

   logic                 start;
   logic                 mem_ready;
   logic [IR_W-1:0]      ir;
   logic [BUS_SEL_W-1:0] bus_sel;
   logic                 bus_drive;
   logic                 mar_in;
   logic                 pc_in;
   logic                 mdr_in;
   logic                 ir_in;
   logic                 y_in;
   logic                 z_in;
   logic                 inc_pc;
   logic                 mem_read;
   logic [REG_N-1:0]     reg_in;
   logic [OPC_W-1:0]     alu_op;
   logic                 busy;
   logic                 done;
   logic                 illegal;

   modport master (
      output start, mem_ready, ir,
      input  bus_sel, bus_drive, mar_in, pc_in, mdr_in, ir_in, y_in, z_in,
             inc_pc, mem_read, reg_in, alu_op, busy, done, illegal
   );

   modport slave (
      input  start, mem_ready, ir,
      output bus_sel, bus_drive, mar_in, pc_in, mdr_in, ir_in, y_in, z_in,
             inc_pc, mem_read, reg_in, alu_op, busy, done, illegal
   );

endinterface

// File: rtl/bus_seq_decode.sv
// Combinational instruction field split and opcode classification.
module bus_seq_decode
   import bus_sequencer_pkg::*;
(
   input  logic [IR_W-1:0] ir,
   output ir_fields_t      fields,
   output logic            is_alu,
   output logic            is_mfhi,
   output logic            is_mflo
);

   // Low instruction bits carry no information for sequencing
   logic unused_low;
   assign unused_low = ^ir[14:0];

   // Field extraction and opcode classes
   assign fields  = ir_fields_t'(ir[31:15]);
   assign is_alu  = (ir[31:27] <= OP_ALU_LAST);
   assign is_mfhi = (ir[31:27] == OP_MFHI);
   assign is_mflo = (ir[31:27] == OP_MFLO);

endmodule

// File: rtl/bus_sequencer.sv
// Fetch/execute control sequencer: Moore decodes of the FSM state, with
// mdr_in the only output that follows mem_ready combinationally in T1.
module bus_sequencer
   import bus_sequencer_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   bus_sequencer_if.slave bus
);

   logic [STATE_W-1:0] state_q, state_d;
   logic               first_q, first_d;   // first cycle of T1
   logic               skip_q, skip_d;     // T5 carries no strobes (MFHI/MFLO)

   ir_fields_t f;
   logic       is_alu, is_mfhi, is_mflo;

   logic [BUS_SEL_W-1:0] bus_sel_c;
   logic                 bus_drive_c, mar_in_c, pc_in_c, mdr_in_c, ir_in_c;
   logic                 y_in_c, z_in_c, inc_pc_c, mem_read_c;
   logic [REG_N-1:0]     reg_in_c;
   logic [OPC_W-1:0]     alu_op_c;
   logic                 busy_c, done_c, illegal_c;

   bus_seq_decode u_decode (
      .ir      (bus.ir),
      .fields  (f),
      .is_alu  (is_alu),
      .is_mfhi (is_mfhi),
      .is_mflo (is_mflo)
   );

   // State register with asynchronous abort to IDLE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         first_q <= 1'b0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         skip_q  <= skip_d;
      end
   end

   // Next-state and per-state output decode
   always_comb begin
      state_d     = state_q;
      first_d     = first_q;
      skip_d      = skip_q;
      bus_sel_c   = '0;
      bus_drive_c = 1'b0;
      mar_in_c    = 1'b0;
      pc_in_c     = 1'b0;
      mdr_in_c    = 1'b0;
      ir_in_c     = 1'b0;
      y_in_c      = 1'b0;
      z_in_c      = 1'b0;
      inc_pc_c    = 1'b0;
      mem_read_c  = 1'b0;
      reg_in_c    = '0;
      alu_op_c    = '0;
      busy_c      = 1'b1;
      done_c      = 1'b0;
      illegal_c   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy_c = 1'b0;
            if (bus.start) state_d = ST_T0;
         end
         ST_T0: begin
            bus_sel_c   = BUS_PC;
            bus_drive_c = 1'b1;
            mar_in_c    = 1'b1;
            inc_pc_c    = 1'b1;
            z_in_c      = 1'b1;
            first_d     = 1'b1;
            state_d     = ST_T1;
         end
         ST_T1: begin
            // PC reload happens once; stall cycles only keep the read going
            mem_read_c  = 1'b1;
            bus_sel_c   = BUS_ZLOW;
            pc_in_c     = first_q;
            bus_drive_c = first_q;
            first_d     = 1'b0;
            if (bus.mem_ready) begin
               mdr_in_c = 1'b1;
               state_d  = ST_T2;
            end
         end
         ST_T2: begin
            bus_sel_c   = BUS_MDR;
            bus_drive_c = 1'b1;
            ir_in_c     = 1'b1;
            state_d     = ST_T3;
         end
         ST_T3: begin
            if (is_alu) begin
               bus_sel_c   = reg_bus_code(f.rb);
               bus_drive_c = 1'b1;
               y_in_c      = 1'b1;
               skip_d      = 1'b0;
               state_d     = ST_T4;
            end else if (is_mfhi || is_mflo) begin
               bus_sel_c   = is_mfhi ? BUS_HI : BUS_LO;
               bus_drive_c = 1'b1;
               reg_in_c    = reg_onehot(f.ra);
               skip_d      = 1'b1;
               state_d     = ST_T5;
            end else begin
               illegal_c = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_T4: begin
            bus_sel_c   = reg_bus_code(f.rc);
            bus_drive_c = 1'b1;
            alu_op_c    = f.opcode;
            z_in_c      = 1'b1;
            state_d     = ST_T5;
         end
         ST_T5: begin
            done_c = 1'b1;
            if (!skip_q) begin
               bus_sel_c   = BUS_ZLOW;
               bus_drive_c = 1'b1;
               reg_in_c    = reg_onehot(f.ra);
            end
            skip_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_c  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Drive the interface
   assign bus.bus_sel   = bus_sel_c;
   assign bus.bus_drive = bus_drive_c;
   assign bus.mar_in    = mar_in_c;
   assign bus.pc_in     = pc_in_c;
   assign bus.mdr_in    = mdr_in_c;
   assign bus.ir_in     = ir_in_c;
   assign bus.y_in      = y_in_c;
   assign bus.z_in      = z_in_c;
   assign bus.inc_pc    = inc_pc_c;
   assign bus.mem_read  = mem_read_c;
   assign bus.reg_in    = reg_in_c;
   assign bus.alu_op    = alu_op_c;
   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.illegal   = illegal_c;

endmodule

// File: tb/tb_bus_sequencer.sv
// Randomized bench for bus_sequencer: a per-instruction trace model expands
// each instruction into the expected cycle-by-cycle strobe pattern.
module tb_bus_sequencer;

   localparam int PH_IDLE = 0;
   localparam int PH_T0   = 1;
   localparam int PH_T1   = 2;
   localparam int PH_T2   = 3;
   localparam int PH_T3   = 4;
   localparam int PH_T4   = 5;
   localparam int PH_T5   = 6;
   localparam int PH_NONE = -1;

   typedef struct packed {
      logic [4:0]  bus_sel;
      logic        bus_drive;
      logic        mar_in;
      logic        pc_in;
      logic        mdr_in;
      logic        ir_in;
      logic        y_in;
      logic        z_in;
      logic        inc_pc;
      logic        mem_read;
      logic [15:0] reg_in;
      logic [4:0]  alu_op;
      logic        busy;
      logic        done;
      logic        illegal;
   } out_t;

   typedef struct {
      int          phase;
      logic        start;
      logic        mem_ready;
      logic [31:0] ir;
      out_t        exp;
   } rec_t;

   logic clk = 1'b0;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   rec_t plan[$];

   always #5 clk = ~clk;

   bus_sequencer_if bif ();

   bus_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bif)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic out_t sample();
      out_t o;
      o.bus_sel   = bif.bus_sel;
      o.bus_drive = bif.bus_drive;
      o.mar_in    = bif.mar_in;
      o.pc_in     = bif.pc_in;
      o.mdr_in    = bif.mdr_in;
      o.ir_in     = bif.ir_in;
      o.y_in      = bif.y_in;
      o.z_in      = bif.z_in;
      o.inc_pc    = bif.inc_pc;
      o.mem_read  = bif.mem_read;
      o.reg_in    = bif.reg_in;
      o.alu_op    = bif.alu_op;
      o.busy      = bif.busy;
      o.done      = bif.done;
      o.illegal   = bif.illegal;
      return o;
   endfunction

   // start_mode: 0 never while busy, 1 random while busy, 2 only in T2
   function automatic void add(input int ph, input logic [31:0] ir, input logic mr,
                               input int start_mode, input out_t e);
      rec_t r;
      r.phase     = ph;
      r.ir        = ir;
      r.mem_ready = mr;
      r.exp       = e;
      r.start     = 1'b0;
      if (start_mode == 1) r.start = 1'($urandom_range(1, 0));
      if (start_mode == 2 && ph == PH_T2) r.start = 1'b1;
      plan.push_back(r);
   endfunction

   // Expected trace of one instruction: IDLE+start, fetch, execute, idle after
   function automatic void plan_txn(input logic [31:0] ir, input int stalls, input int start_mode);
      out_t e;
      int   opc = int'(ir[31:27]);
      int   ra  = int'(ir[26:23]);
      int   rb  = int'(ir[22:19]);
      int   rc  = int'(ir[18:15]);
      rec_t r;

      e = '0;
      r.phase = PH_IDLE; r.ir = ir; r.mem_ready = 1'($urandom_range(1, 0));
      r.start = 1'b1; r.exp = e;
      plan.push_back(r);

      e = '0; e.busy = 1; e.bus_sel = 5'd3; e.bus_drive = 1;
      e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
      add(PH_T0, ir, 1'($urandom_range(1, 0)), start_mode, e);

      for (int i = 0; i <= stalls; i++) begin
         e = '0; e.busy = 1; e.mem_read = 1; e.bus_sel = 5'd4;
         e.pc_in = (i == 0); e.bus_drive = (i == 0); e.mdr_in = (i == stalls);
         add(PH_T1, ir, (i == stalls), start_mode, e);
      end

      e = '0; e.busy = 1; e.bus_sel = 5'd2; e.bus_drive = 1; e.ir_in = 1;
      add(PH_T2, ir, 1'($urandom_range(1, 0)), start_mode, e);

      if (opc <= 12) begin
         e = '0; e.busy = 1; e.bus_sel = 5'(23 - rb); e.bus_drive = 1; e.y_in = 1;
         add(PH_T3, ir, 1'($urandom_range(1, 0)), start_mode, e);
         e = '0; e.busy = 1; e.bus_sel = 5'(23 - rc); e.bus_drive = 1; e.z_in = 1;
         e.alu_op = 5'(opc);
         add(PH_T4, ir, 1'($urandom_range(1, 0)), start_mode, e);
         e = '0; e.busy = 1; e.done = 1; e.bus_sel = 5'd4; e.bus_drive = 1;
         e.reg_in = 16'(1) << ra;
         add(PH_T5, ir, 1'($urandom_range(1, 0)), start_mode, e);
      end else if (opc == 16 || opc == 17) begin
         e = '0; e.busy = 1; e.bus_sel = (opc == 16) ? 5'd7 : 5'd6; e.bus_drive = 1;
         e.reg_in = 16'(1) << ra;
         add(PH_T3, ir, 1'($urandom_range(1, 0)), start_mode, e);
         e = '0; e.busy = 1; e.done = 1;
         add(PH_T5, ir, 1'($urandom_range(1, 0)), start_mode, e);
      end else begin
         e = '0; e.busy = 1; e.illegal = 1;
         add(PH_T3, ir, 1'($urandom_range(1, 0)), start_mode, e);
      end

      e = '0;
      add(PH_IDLE, ir, 1'($urandom_range(1, 0)), 0, e);
   endfunction

   // Play the plan; optionally abort with reset in the first cycle of abort_ph
   task automatic run_plan(input int txn, input int abort_ph);
      rec_t r;
      int   c = 0;
      while (plan.size() > 0) begin
         r = plan.pop_front();
         @(negedge clk);
         bif.start = r.start; bif.mem_ready = r.mem_ready; bif.ir = r.ir;
         #1;
         check_eq($sformatf("t%0d_c%0d_ph%0d", txn, c, r.phase), 64'(sample()), 64'(r.exp));
         c++;
         if (r.phase == abort_ph) begin
            #1 reset_n = 1'b0;
            #1 check_eq($sformatf("t%0d_async_rst", txn), 64'(sample()), 64'd0);
            plan.delete();
            for (int k = 0; k < 2; k++) begin
               @(negedge clk);
               bif.start = 1'b1; bif.mem_ready = 1'b1;
               #1 check_eq($sformatf("t%0d_in_rst%0d", txn, k), 64'(sample()), 64'd0);
            end
            @(negedge clk);
            bif.start = 1'b0; reset_n = 1'b1;
            #1 check_eq($sformatf("t%0d_post_rst", txn), 64'(sample()), 64'd0);
         end
      end
   endtask

   function automatic logic [31:0] rand_ir();
      logic [4:0] opc;
      int         sel = $urandom_range(9, 0);
      if (sel < 6)       opc = 5'($urandom_range(12, 0));
      else if (sel == 6) opc = 5'd16;
      else if (sel == 7) opc = 5'd17;
      else               opc = 5'($urandom_range(31, 13));
      return {opc, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
              4'($urandom_range(15, 0)), 15'($urandom_range(32767, 0))};
   endfunction

   initial begin
      reset_n = 1'b0;
      bif.start = 1'b0; bif.mem_ready = 1'b0; bif.ir = '0;
      #1 check_eq("reset_state", 64'(sample()), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // ALU op 3, ra=1 rb=2 rc=3, memory always ready
      plan_txn({5'd3, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 0);
      run_plan(0, PH_NONE);
      // Three stall cycles in T1
      plan_txn({5'd5, 4'd7, 4'd0, 4'd15, 15'h1234}, 3, 0);
      run_plan(1, PH_NONE);
      // MFHI into R15, then MFLO into R0
      plan_txn({5'd16, 4'd15, 4'd0, 4'd0, 15'd0}, 0, 0);
      run_plan(2, PH_NONE);
      plan_txn({5'd17, 4'd0, 4'd9, 4'd9, 15'd0}, 1, 0);
      run_plan(3, PH_NONE);
      // Illegal opcodes at both ends of the gap
      plan_txn({5'd31, 4'd3, 4'd3, 4'd3, 15'd0}, 0, 0);
      run_plan(4, PH_NONE);
      plan_txn({5'd13, 4'd3, 4'd3, 4'd3, 15'd0}, 0, 0);
      run_plan(5, PH_NONE);
      // Reset during T4, then a normal sequence
      plan_txn({5'd12, 4'd4, 4'd5, 4'd6, 15'd0}, 0, 0);
      run_plan(6, PH_T4);
      plan_txn({5'd0, 4'd14, 4'd1, 4'd2, 15'd0}, 0, 0);
      run_plan(7, PH_NONE);
      // Reset during a T1 stall
      plan_txn({5'd1, 4'd2, 4'd2, 4'd2, 15'd0}, 3, 0);
      run_plan(8, PH_T1);
      // start pulsed in T2 must not queue a second sequence
      plan_txn({5'd7, 4'd8, 4'd10, 4'd11, 15'd0}, 0, 2);
      run_plan(9, PH_NONE);

      for (int t = 10; t < 70; t++) begin
         plan_txn(rand_ir(), $urandom_range(3, 0), 1);
         run_plan(t, PH_NONE);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  begin one fetch/execute cycle; sampled only in IDLE.
REQ-004 mem_ready  input  1  memory read data valid at the MDR input.
REQ-005 ir  input  32  instruction register contents; opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15].
REQ-006 bus_sel  output  5  source select for the shared-bus mux: R0..R15 = 23..8, HI = 7, LO = 6, Zhigh = 5, Zlow = 4, PC = 3, MDR = 2, InPort = 1, C = 0.
REQ-007 bus_drive  output  1  bus_sel is meaningful this cycle; 0 means no source is driven.
REQ-008 mar_in, pc_in, mdr_in, ir_in, y_in, z_in, inc_pc, mem_read  output  1 each  load and control strobes.
REQ-009 reg_in  output  16  one-hot or zero write enable for R0..R15.
REQ-010 alu_op  output  5  ALU operation code.
REQ-011 busy, done, illegal  output  1 each  status outputs.

Function
REQ-012 The FSM SHALL have the states IDLE, T0, T1, T2, T3, T4, T5; exactly one state per cycle except T1, which holds on a stall.
REQ-013 IDLE: all strobes SHALL be 0, bus_drive = 0, and busy = 0; start = 1 moves to T0.
REQ-014 T0: bus_sel = 3 and bus_drive = 1; mar_in, inc_pc and z_in SHALL be 1; next state is T1.
REQ-015 T1: mem_read = 1, bus_sel = 4, pc_in = 1 on the first T1 cycle only. mdr_in = 1 in the cycle mem_ready = 1, then go to T2; otherwise stay in T1.
REQ-016 T2: bus_sel = 2 and ir_in = 1; next state is T3.
REQ-017 Decode in T3 uses ir[31:27]. Opcodes 0..12 are ALU ops, 16 is MFHI, 17 is MFLO. Any other opcode SHALL pulse illegal = 1 for one cycle in T3 with no strobes, then return to IDLE.
REQ-018 ALU path:
  - T3: bus_sel = 23 - rb, y_in = 1.
  - T4: bus_sel = 23 - rc, alu_op = opcode, z_in = 1.
  - T5: bus_sel = 4, reg_in[ra] = 1.
REQ-019 MFHI/MFLO path: T3 SHALL use bus_sel = 7 or 6 with reg_in[ra] = 1, then go to T5_skip, which is T5 with no strobes (done only).
REQ-020 done SHALL pulse for one cycle in the final T5 cycle, and the FSM returns to IDLE.
REQ-021 alu_op SHALL be 0 in every state except T4.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 bus_drive SHALL be 1 exactly in cycles where some *_in or reg_in strobe consumes the bus.
REQ-024 At most one bus source SHALL be selected per cycle, and reg_in SHALL never have more than one bit set.
REQ-025 start asserted while busy SHALL be ignored and not queued.
REQ-026 mem_ready asserted outside T1 SHALL be ignored.
REQ-027 All outputs SHALL be registered-state decodes (Moore), except mdr_in, which is combinational on mem_ready in T1.

Reset
REQ-028 reset_n = 0 SHALL force IDLE immediately, with every output 0, including bus_sel = 0 and bus_drive = 0.
REQ-029 A reset asserted mid-sequence, including a T1 stall, SHALL abort the sequence with no done pulse.
REQ-030 After reset_n rises, the first cycle SHALL be IDLE.

Structure
REQ-031 A shared package SHALL hold:
  - the state encoding;
  - the bus source codes (REQ-006);
  - the opcode constants, including MFHI = 16 and MFLO = 17.
REQ-032 The block SHALL be a single module; the ir field decode MAY be a sub-module named bus_seq_decode, which is combinational.

Verification
REQ-033 Reset, then start with ir = opcode 3, ra = 1, rb = 2, rc = 3, mem_ready tied high. Required response:
  - bus_sel sequence 3, 4, 2, 21, 20, 4;
  - alu_op = 3 only in T4;
  - reg_in = 16'h0002 in T5;
  - done on cycle 6.
REQ-034 Hold mem_ready low for 3 cycles in T1. Required response: T1 lasts 4 cycles, pc_in = 1 only in the first of them, and mdr_in = 1 only in the fourth.
REQ-035 ir opcode 16, ra = 15. Required response: T3 drives bus_sel = 7 with reg_in = 16'h8000, and done follows.
REQ-036 ir opcode 31. Required response: illegal pulses in T3, no reg_in ever asserts, and busy drops the next cycle.
REQ-037 Assert reset_n = 0 during T4. Required response: all outputs go to 0 asynchronously and there is no done pulse. A subsequent start runs a full sequence normally.
REQ-038 Assert start during T2. Required response: it is ignored, and exactly one done pulse occurs.
